// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: deserialises set-2 scancodes, tracks make/break and presents the held key as ASCII.
// Define KBD_SHIFT_EN to add left/right shift tracking with uppercase letters.
module ps2_keyboard #(
   parameter int          TIMEOUT_CYCLES = 10000,
   parameter logic [7:0]  NO_KEY         = 8'hFF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] bus_keyboard,
   output logic       key_strobe,
   output logic       frame_error
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int             TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

   state_t          state, state_next;
   logic            clk_s1, clk_s2, clk_prev, data_s1, data_s2;
   logic            fe, rx_bit;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic            parity_bit;
   logic [TW-1:0]   timeout_cnt;
   logic            load_bit, load_parity, accept, reject, timeout_hit;
   logic [7:0]      code_reg;
   logic            code_valid;
   logic            break_pending, ext_pending;
   logic [7:0]      xlat, make_val;
   logic            release_match;

   // Idle level of both PS/2 lines is high, so the synchronisers reset to 1.
   always_ff @(posedge clock) begin
      if (!reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   assign fe     = clk_prev & ~clk_s2;
   assign rx_bit = data_s2;

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (fe && !rx_bit)            state_next = DATA;
         DATA:    if (fe && bit_cnt == 3'd7)    state_next = PARITY;
         PARITY:  if (fe)                       state_next = STOP;
         STOP:    if (fe)                       state_next = IDLE;
         default:                               state_next = IDLE;
      endcase
      if (timeout_hit) state_next = IDLE;
   end

   always_comb begin
      load_bit    = 1'b0;
      load_parity = 1'b0;
      accept      = 1'b0;
      reject      = 1'b0;
      timeout_hit = (state != IDLE) && !fe && (timeout_cnt == TIMEOUT_MAX);
      case (state)
         DATA:    load_bit    = fe;
         PARITY:  load_parity = fe;
         STOP: begin
            if (fe) begin
               if (rx_bit && (^{shift_reg, parity_bit})) accept = 1'b1;
               else                                      reject = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         bit_cnt     <= '0;
         shift_reg   <= '0;
         parity_bit  <= 1'b0;
         timeout_cnt <= '0;
         code_reg    <= '0;
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         code_valid  <= accept;
         frame_error <= reject | timeout_hit;
         if (accept) code_reg <= shift_reg;
         if (fe || state == IDLE) timeout_cnt <= '0;
         else                     timeout_cnt <= timeout_cnt + 1'b1;
         if (state == IDLE && fe) bit_cnt <= '0;
         if (load_bit) begin
            shift_reg <= {rx_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
         if (load_parity) parity_bit <= rx_bit;
      end
   end

   function automatic logic [7:0] translate(input logic [7:0] code);
      case (code)
         8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;  8'h23: return 8'h64;
         8'h24: return 8'h65;  8'h2B: return 8'h66;  8'h34: return 8'h67;  8'h33: return 8'h68;
         8'h43: return 8'h69;  8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
         8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;  8'h4D: return 8'h70;
         8'h15: return 8'h71;  8'h2D: return 8'h72;  8'h1B: return 8'h73;  8'h2C: return 8'h74;
         8'h3C: return 8'h75;  8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
         8'h35: return 8'h79;  8'h1A: return 8'h7A;
         8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
         8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;  8'h3D: return 8'h37;
         8'h3E: return 8'h38;  8'h46: return 8'h39;
         8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;  8'h76: return 8'h1B;
         default: return NO_KEY;
      endcase
   endfunction

   assign xlat = translate(code_reg);

`ifdef KBD_SHIFT_EN
   logic shift_held;
   logic is_shift_code;

   assign is_shift_code = (code_reg == 8'h12) || (code_reg == 8'h59);
   assign make_val      = (shift_held && xlat >= 8'h61 && xlat <= 8'h7A) ? (xlat & 8'hDF) : xlat;
   // A letter released after shift changed may be held in the other case; fold to lowercase.
   assign release_match = (((bus_keyboard >= 8'h41 && bus_keyboard <= 8'h5A) ?
                            (bus_keyboard | 8'h20) : bus_keyboard) == xlat);
`else
   assign make_val      = xlat;
   assign release_match = (bus_keyboard == xlat);
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         bus_keyboard  <= NO_KEY;
         key_strobe    <= 1'b0;
         break_pending <= 1'b0;
         ext_pending   <= 1'b0;
`ifdef KBD_SHIFT_EN
         shift_held    <= 1'b0;
`endif
      end else begin
         key_strobe <= 1'b0;
         if (code_valid) begin
            if (code_reg == 8'hF0) begin
               break_pending <= 1'b1;
            end else if (code_reg == 8'hE0) begin
               ext_pending <= 1'b1;
            end else if (ext_pending) begin
               ext_pending   <= 1'b0;
               break_pending <= 1'b0;
`ifdef KBD_SHIFT_EN
            end else if (is_shift_code) begin
               shift_held    <= !break_pending;
               break_pending <= 1'b0;
`endif
            end else if (break_pending) begin
               break_pending <= 1'b0;
               if (release_match) bus_keyboard <= NO_KEY;
            end else if (xlat != NO_KEY) begin
               bus_keyboard <= make_val;
               key_strobe   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random scancode traffic against a table-driven model.
// Honours KBD_SHIFT_EN to match the design build.
module tb_ps2_keyboard;

   localparam int HALF = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] bus_keyboard;
   logic       key_strobe;
   logic       frame_error;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int strobeCount = 0;
   int errorCount = 0;
   int lastStrobeCycle = 0;
   int feCycle = 0;

   logic [7:0] mHeld = 8'hFF;
   logic       mBrk = 1'b0;
   logic       mExt = 1'b0;
   logic       mShift = 1'b0;

   logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digitCodes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] ctrlCodes [4]    = '{8'h29, 8'h5A, 8'h66, 8'h76};
   logic [7:0] oddCodes [6]     = '{8'h05, 8'h0D, 8'h7C, 8'h83, 8'h12, 8'h59};

   ps2_keyboard dut (
      .clock        (clock),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .bus_keyboard (bus_keyboard),
      .key_strobe   (key_strobe),
      .frame_error  (frame_error)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc++;

   // Pulse counters run continuously so stray or doubled pulses are visible in the per-frame deltas.
   always @(negedge clock) begin
      if (key_strobe) begin
         strobeCount++;
         lastStrobeCycle = cyc;
      end
      if (frame_error) errorCount++;
   end

   function automatic logic [7:0] modelTranslate(input logic [7:0] c);
      for (int i = 0; i < 26; i++) if (letterCodes[i] == c) return 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) if (digitCodes[i] == c) return 8'h30 + 8'(i);
      case (c)
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         8'h76: return 8'h1B;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] lowerCase(input logic [7:0] v);
      return (v >= 8'h41 && v <= 8'h5A) ? v + 8'h20 : v;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sendBit(input logic b);
      ps2_data = b;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      feCycle = cyc;
      waitCycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic sendPartial(input int nbits);
      sendBit(1'b0);
      for (int i = 0; i < nbits; i++) sendBit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
   endtask

   // Updates the reference model for one accepted code; returns the expected strobe count.
   task automatic modelAccept(input logic [7:0] c, output int expStrobe);
      logic [7:0] t;
      expStrobe = 0;
      t = modelTranslate(c);
      if (c == 8'hF0) mBrk = 1'b1;
      else if (c == 8'hE0) mExt = 1'b1;
      else if (mExt) begin
         mExt = 1'b0;
         mBrk = 1'b0;
      end
`ifdef KBD_SHIFT_EN
      else if (c == 8'h12 || c == 8'h59) begin
         mShift = !mBrk;
         mBrk = 1'b0;
      end
`endif
      else if (mBrk) begin
         mBrk = 1'b0;
         if (lowerCase(mHeld) == lowerCase(t)) mHeld = 8'hFF;
      end else if (t != 8'hFF) begin
         mHeld = (mShift && t >= 8'h61 && t <= 8'h7A) ? t - 8'h20 : t;
         expStrobe = 1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] code, input logic badParity, input logic badStop);
      int sB, eB, expStrobe, expErr;
      logic par;
      sB = strobeCount;
      eB = errorCount;
      par = ~(^code) ^ badParity;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(code[i]);
      sendBit(par);
      sendBit(!badStop);
      ps2_data = 1'b1;
      waitCycles(HALF);
      expErr = 0;
      expStrobe = 0;
      if (badParity || badStop) expErr = 1;
      else modelAccept(code, expStrobe);
      checkOutput($sformatf("bus_%02h", code), 32'(bus_keyboard), 32'(mHeld));
      checkOutput($sformatf("strobes_%02h", code), 32'(strobeCount - sB), 32'(expStrobe));
      checkOutput($sformatf("errors_%02h", code), 32'(errorCount - eB), 32'(expErr));
      if (expStrobe == 1)
         checkOutput($sformatf("latency_%02h", code), 32'(lastStrobeCycle - feCycle), 32'd4);
   endtask

   task automatic resetModel();
      mHeld = 8'hFF;
      mBrk = 1'b0;
      mExt = 1'b0;
      mShift = 1'b0;
   endtask

   initial begin
      int r, e0;
      logic [7:0] code;

      reset = 1'b0;
      waitCycles(4);
      checkOutput("reset_bus", 32'(bus_keyboard), 32'hFF);
      checkOutput("reset_strobe", 32'(key_strobe), 32'd0);
      checkOutput("reset_error", 32'(frame_error), 32'd0);
      reset = 1'b1;
      waitCycles(4);

      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'h29, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);

      applyStimulus(8'h1C, 1'b1, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1);

      sendPartial(3);
      reset = 1'b0;
      waitCycles(2);
      checkOutput("midframe_reset_bus", 32'(bus_keyboard), 32'hFF);
      checkOutput("midframe_reset_strobe", 32'(key_strobe), 32'd0);
      checkOutput("midframe_reset_error", 32'(frame_error), 32'd0);
      resetModel();
      reset = 1'b1;
      waitCycles(4);
      applyStimulus(8'h1C, 1'b0, 1'b0);

      e0 = errorCount;
      sendPartial(4);
      for (int i = 0; i < 10200 && errorCount == e0; i++) waitCycles(1);
      waitCycles(4);
      checkOutput("timeout_error", 32'(errorCount - e0), 32'd1);
      checkOutput("timeout_bus", 32'(bus_keyboard), 32'(mHeld));
      applyStimulus(8'h5A, 1'b0, 1'b0);

      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b0);
      applyStimulus(8'h12, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h12, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
`ifdef KBD_SHIFT_EN
      checkOutput("shift_release_lower", 32'(bus_keyboard), 32'h61);
`endif

      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      code = letterCodes[$urandom_range(0, 25)];
         else if (r < 45) code = digitCodes[$urandom_range(0, 9)];
         else if (r < 55) code = ctrlCodes[$urandom_range(0, 3)];
         else if (r < 75) code = 8'hF0;
         else if (r < 80) code = 8'hE0;
         else             code = oddCodes[$urandom_range(0, 5)];
         r = $urandom_range(0, 9);
         applyStimulus(code, r == 0, r == 1);
      end

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
